delivery_event_sequencer: RTL and testbench

Upstream feeder for the cricket scorecard. It accepts one delivery outcome per handshake and expands it into single-cycle increment pulses: one run pulse per run, one ball pulse for a legal delivery, and one wicket pulse. Pulses are spaced so the edge-triggered score, ball and wicket counters downstream see one clean rising edge per increment. It also tracks legal balls and wickets itself, and closes the innings at the configured limit.

---
 rtl/delivery_event_sequencer_pkg.sv | 39 +++
 rtl/delivery_event_sequencer_if.sv | 27 ++
 rtl/delivery_event_sequencer_pulse_gap_timer.sv | 42 ++++
 rtl/delivery_event_sequencer.sv | 163 ++++++++++++++++
 tb/tb_delivery_event_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/delivery_event_sequencer_pkg.sv
// Shared types and constants for the cricket delivery event sequencer.
// Holds delivery-type and sequencer-state enums plus the run-clamp helper.
package cric_pkg;

    typedef enum logic [1:0] {
        LEGAL  = 2'b00,
        WIDE   = 2'b01,
        NOBALL = 2'b10,
        BYE    = 2'b11
    } extra_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        BALL,
        WKT,
        GAP,
        FIN
    } seq_state_t;

    typedef struct packed {
        logic wkt;
        logic ball;
        logic run;
    } pulse_t;

    localparam int BALLS_PER_OVER    = 6;
    localparam int MAX_RUNS_PER_BALL = 6;

    function automatic logic [2:0] clamp_runs(input logic [2:0] runs);
        return (int'(runs) > MAX_RUNS_PER_BALL) ? 3'(MAX_RUNS_PER_BALL) : runs;
    endfunction

    // Wides and no-balls add a penalty run and do not count as a ball.
    function automatic logic is_free_ball(input extra_t ex);
        return (ex == WIDE) || (ex == NOBALL);
    endfunction

endpackage

// File: rtl/delivery_event_sequencer_if.sv
// Delivery event handshake and increment-pulse bundle between the event
// source (master) and the sequencer (slave).
interface delivery_event_sequencer_if;
    import cric_pkg::*;

    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_runs;
    extra_t     ev_extra;
    logic       ev_wkt;
    logic       inc_run;
    logic       inc_ball;
    logic       inc_wkt;
    logic       busy;
    logic       innings_done;

    modport master (
        output ev_valid, ev_runs, ev_extra, ev_wkt,
        input  ev_ready, inc_run, inc_ball, inc_wkt, busy, innings_done
    );

    modport slave (
        input  ev_valid, ev_runs, ev_extra, ev_wkt,
        output ev_ready, inc_run, inc_ball, inc_wkt, busy, innings_done
    );

endinterface

// File: rtl/delivery_event_sequencer_pulse_gap_timer.sv
// Emits a registered one-hot pulse on request, then keeps done low until
// GAP quiet cycles have elapsed (done is high in the last quiet cycle).
module pulse_gap_timer #(
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fire_i,
    input  logic [2:0] sel_i,
    output logic [2:0] pulse_o,
    output logic       done_o
);

    localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;
    logic [2:0]    pulse_q;

    always_comb begin
        gap_d = gap_q;
        if (fire_i) begin
            gap_d = GW'(GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q   <= '0;
            pulse_q <= '0;
        end else begin
            gap_q   <= gap_d;
            pulse_q <= fire_i ? sel_i : 3'b000;
        end
    end

    assign pulse_o = pulse_q;
    assign done_o  = (gap_q == '0);

endmodule

// File: rtl/delivery_event_sequencer.sv
// Expands one accepted delivery into spaced run/ball/wicket increment pulses
// and tracks balls, overs and wickets to close the innings at its limits.
module delivery_event_sequencer #(
    parameter int MAX_OVERS = 20,
    parameter int MAX_WKTS  = 10,
    parameter int GAP       = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    delivery_event_sequencer_if.slave bus
);
    import cric_pkg::*;

    localparam int OW = $clog2(MAX_OVERS + 1);
    localparam int WW = $clog2(MAX_WKTS + 1);
    localparam int BW = $clog2(BALLS_PER_OVER);
    localparam int RW = $clog2(MAX_RUNS_PER_BALL + 2);

    seq_state_t    state_q;
    seq_state_t    pick_state;
    logic [RW-1:0] runs_q, src_runs, runs_nx;
    logic          ball_pend_q, wkt_pend_q;
    logic          src_ball, src_wkt, ball_nx, wkt_nx;
    logic          legal_q, wkt_evt_q;
    logic [BW-1:0] bio_q, bio_d;
    logic [OW-1:0] overs_q, overs_d;
    logic [WW-1:0] wkts_q, wkts_d;
    logic          limit_d;
    logic          done_q, ready_q, busy_q;
    logic          accept, step, fire, timer_done, ev_legal;
    pulse_t        sel, pulses;

    // Pick the next pulse either from a fresh event or from what is still pending.
    always_comb begin
        accept   = bus.ev_valid && ready_q;
        ev_legal = !is_free_ball(bus.ev_extra);
        step     = accept || ((state_q == cric_pkg::GAP) && timer_done);

        if (accept) begin
            src_runs = RW'(clamp_runs(bus.ev_runs)) + RW'(!ev_legal);
            src_ball = ev_legal;
            src_wkt  = bus.ev_wkt;
        end else begin
            src_runs = runs_q;
            src_ball = ball_pend_q;
            src_wkt  = wkt_pend_q;
        end

        pick_state = FIN;
        sel        = '0;
        if (src_runs != '0) begin
            pick_state = RUN;
            sel.run    = 1'b1;
        end else if (src_ball) begin
            pick_state = BALL;
            sel.ball   = 1'b1;
        end else if (src_wkt) begin
            pick_state = WKT;
            sel.wkt    = 1'b1;
        end

        fire    = step && (pick_state != FIN);
        runs_nx = (pick_state == RUN) ? (src_runs - RW'(1)) : src_runs;
        ball_nx = src_ball && (pick_state != BALL);
        wkt_nx  = src_wkt && (pick_state != WKT);
    end

    always_comb begin
        bio_d   = bio_q;
        overs_d = overs_q;
        wkts_d  = wkts_q;
        if (legal_q) begin
            if (bio_q == BW'(BALLS_PER_OVER - 1)) begin
                bio_d   = '0;
                overs_d = overs_q + OW'(1);
            end else begin
                bio_d = bio_q + BW'(1);
            end
        end
        if (wkt_evt_q) begin
            wkts_d = wkts_q + WW'(1);
        end
        limit_d = (int'(wkts_d) >= MAX_WKTS) || (int'(overs_d) >= MAX_OVERS);
    end

    pulse_gap_timer #(
        .GAP(GAP)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .fire_i (fire),
        .sel_i  (sel),
        .pulse_o(pulses),
        .done_o (timer_done)
    );

    // FIN doubles as an accept slot, so back-to-back events lose no cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            runs_q      <= '0;
            ball_pend_q <= 1'b0;
            wkt_pend_q  <= 1'b0;
            legal_q     <= 1'b0;
            wkt_evt_q   <= 1'b0;
            bio_q       <= '0;
            overs_q     <= '0;
            wkts_q      <= '0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    if (accept) begin
                        state_q     <= pick_state;
                        runs_q      <= runs_nx;
                        ball_pend_q <= ball_nx;
                        wkt_pend_q  <= wkt_nx;
                        legal_q     <= ev_legal;
                        wkt_evt_q   <= bus.ev_wkt;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN, BALL, WKT: begin
                    state_q <= cric_pkg::GAP;
                end
                cric_pkg::GAP: begin
                    if (timer_done) begin
                        if (fire) begin
                            state_q     <= pick_state;
                            runs_q      <= runs_nx;
                            ball_pend_q <= ball_nx;
                            wkt_pend_q  <= wkt_nx;
                        end else begin
                            state_q <= FIN;
                            bio_q   <= bio_d;
                            overs_q <= overs_d;
                            wkts_q  <= wkts_d;
                            done_q  <= limit_d;
                            ready_q <= !limit_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ev_ready     = ready_q;
    assign bus.busy         = busy_q;
    assign bus.innings_done = done_q;
    assign bus.inc_run      = pulses.run;
    assign bus.inc_ball     = pulses.ball;
    assign bus.inc_wkt      = pulses.wkt;

endmodule

// File: tb/tb_delivery_event_sequencer.sv
// Self-checking bench: a default-limit instance and a short-innings GAP=2
// instance, checked cycle by cycle against a timeline model of each delivery.
module tb_delivery_event_sequencer;
    import cric_pkg::*;

    typedef struct {
        int     runs;
        extra_t extra;
        bit     wkt;
        int     expRuns;
        int     expBalls;
        int     expWkts;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstA_n, rstB_n;
    logic       evValid;
    logic [2:0] evRuns;
    extra_t     evExtra;
    logic       evWkt;
    bit         useB;

    int nVec = 0;
    int nMis = 0;
    int cfgGap, cfgOvers, cfgWkts;
    int mBalls, mWkts;
    bit mDone;

    delivery_event_sequencer_if ifA ();
    delivery_event_sequencer_if ifB ();

    assign ifA.ev_valid = evValid && !useB;
    assign ifA.ev_runs  = evRuns;
    assign ifA.ev_extra = evExtra;
    assign ifA.ev_wkt   = evWkt;
    assign ifB.ev_valid = evValid && useB;
    assign ifB.ev_runs  = evRuns;
    assign ifB.ev_extra = evExtra;
    assign ifB.ev_wkt   = evWkt;

    delivery_event_sequencer #(.MAX_OVERS(20), .MAX_WKTS(10), .GAP(1)) dutA (
        .clk  (clk),
        .rst_n(rstA_n),
        .bus  (ifA)
    );

    delivery_event_sequencer #(.MAX_OVERS(1), .MAX_WKTS(2), .GAP(2)) dutB (
        .clk  (clk),
        .rst_n(rstB_n),
        .bus  (ifB)
    );

    always #5 clk = ~clk;

    // Bit order: inc_run, inc_ball, inc_wkt, busy, ev_ready, innings_done.
    function automatic logic [5:0] observe();
        if (useB)
            return {ifB.inc_run, ifB.inc_ball, ifB.inc_wkt, ifB.busy, ifB.ev_ready, ifB.innings_done};
        return {ifA.inc_run, ifA.inc_ball, ifA.inc_wkt, ifA.busy, ifA.ev_ready, ifA.innings_done};
    endfunction

    task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %b, expected %b (run,ball,wkt,busy,ready,done)", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0d pulses, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit valid, input int runs, input extra_t ex, input bit wkt);
        evValid = valid;
        evRuns  = 3'(runs);
        evExtra = ex;
        evWkt   = wkt;
    endtask

    task automatic selectDut(input bit b);
        useB      = b;
        cfgGap    = b ? 2 : 1;
        cfgOvers  = b ? 1 : 20;
        cfgWkts   = b ? 2 : 10;
        mBalls    = 0;
        mWkts     = 0;
        mDone     = 0;
    endtask

    // Called at a negedge while the selected DUT is idle; ends at the negedge after FIN.
    task automatic runEvent(input string name, input int runs, input extra_t ex, input bit wkt,
                            output int nRun, output int nBall, output int nWkt);
        int r, n, fin, k;
        bit l, free, limit;
        logic [5:0] exp, act;
        nRun = 0;
        nBall = 0;
        nWkt = 0;
        if (mDone) begin
            applyStimulus(1, runs, ex, wkt);
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("%s/ignored@c%0d", name, c), observe(), 6'b000001);
            end
            applyStimulus(0, 0, LEGAL, 0);
            return;
        end
        free = (ex == WIDE) || (ex == NOBALL);
        l    = !free;
        r    = ((runs > 6) ? 6 : runs) + (free ? 1 : 0);
        n    = r + int'(l) + int'(wkt);
        fin  = n * (1 + cfgGap) + 1;
        if (l) mBalls++;
        if (wkt) mWkts++;
        limit = (mWkts >= cfgWkts) || ((mBalls / 6) >= cfgOvers);

        applyStimulus(1, runs, ex, wkt);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 0, LEGAL, 0);
        for (int c = 1; c <= fin + 1; c++) begin
            k   = (c - 1) / (1 + cfgGap);
            exp = '0;
            if (((c - 1) % (1 + cfgGap)) == 0 && k < n) begin
                if (k < r)             exp[5] = 1'b1;
                else if (k == r && l)  exp[4] = 1'b1;
                else                   exp[3] = 1'b1;
            end
            exp[2] = (c <= fin);
            exp[1] = (c >= fin) && !limit;
            exp[0] = (c >= fin) && limit;
            act = observe();
            checkOutput($sformatf("%s@c%0d", name, c), act, exp);
            nRun  += (act[5] === 1'b1) ? 1 : 0;
            nBall += (act[4] === 1'b1) ? 1 : 0;
            nWkt  += (act[3] === 1'b1) ? 1 : 0;
            if (c <= fin) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        mDone = limit;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        int nr, nb, nw;
        tbl[0] = '{4, LEGAL,  1'b0, 4, 1, 0};
        tbl[1] = '{2, WIDE,   1'b1, 3, 0, 1};
        tbl[2] = '{7, LEGAL,  1'b0, 6, 1, 0};
        tbl[3] = '{0, NOBALL, 1'b0, 1, 0, 0};
        tbl[4] = '{3, BYE,    1'b0, 3, 1, 0};
        tbl[5] = '{0, LEGAL,  1'b1, 0, 1, 1};
        tbl[6] = '{6, NOBALL, 1'b1, 7, 0, 1};
        tbl[7] = '{0, WIDE,   1'b0, 1, 0, 0};

        applyStimulus(0, 0, LEGAL, 0);
        useB   = 0;
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        repeat (2) @(negedge clk);
        selectDut(0);
        checkOutput("resetA", observe(), 6'b000010);
        selectDut(1);
        checkOutput("resetB", observe(), 6'b000010);
        rstA_n = 1'b1;
        rstB_n = 1'b1;
        @(negedge clk);

        selectDut(0);
        for (int i = 0; i < 8; i++) begin
            runEvent($sformatf("tbl%0d", i), tbl[i].runs, tbl[i].extra, tbl[i].wkt, nr, nb, nw);
            checkCount($sformatf("tbl%0d/runs", i), nr, tbl[i].expRuns);
            checkCount($sformatf("tbl%0d/balls", i), nb, tbl[i].expBalls);
            checkCount($sformatf("tbl%0d/wkts", i), nw, tbl[i].expWkts);
        end

        // One-over innings: a wide with a wicket in the middle must not use up a ball.
        selectDut(1);
        for (int i = 0; i < 5; i++) runEvent($sformatf("dot%0d", i), 0, LEGAL, 0, nr, nb, nw);
        runEvent("wideWkt", 2, WIDE, 1, nr, nb, nw);
        checkCount("wideWkt/runs", nr, 3);
        checkCount("wideWkt/wkts", nw, 1);
        checkOutput("afterWide", observe(), 6'b000010);
        runEvent("dot6", 0, LEGAL, 0, nr, nb, nw);
        checkOutput("oversDone", observe(), 6'b000001);
        runEvent("seventh", 0, LEGAL, 0, nr, nb, nw);

        rstB_n = 1'b0;
        @(negedge clk);
        rstB_n = 1'b1;
        @(negedge clk);
        selectDut(1);
        runEvent("wktBall7", 7, LEGAL, 1, nr, nb, nw);
        checkCount("wktBall7/runs", nr, 6);
        checkOutput("oneWkt", observe(), 6'b000010);
        runEvent("wktNoball", 0, NOBALL, 1, nr, nb, nw);
        checkOutput("wktsDone", observe(), 6'b000001);

        // Abort a six during its third run pulse.
        rstA_n = 1'b0;
        @(negedge clk);
        rstA_n = 1'b1;
        @(negedge clk);
        selectDut(0);
        applyStimulus(1, 6, LEGAL, 0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 0, LEGAL, 0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("thirdRun", observe(), 6'b100100);
        rstA_n = 1'b0;
        #1;
        checkOutput("abort", observe(), 6'b000010);
        repeat (2) @(negedge clk);
        rstA_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("postAbort@%0d", c), observe(), 6'b000010);
        end

        selectDut(0);
        for (int i = 0; i < 50; i++) begin
            int rr, ee;
            bit ww;
            rr = $urandom_range(0, 7);
            ee = $urandom_range(0, 3);
            ww = ($urandom_range(0, 9) == 0);
            runEvent($sformatf("rand%0d", i), rr, extra_t'(ee[1:0]), ww, nr, nb, nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
